pbw_motor_sequencer: RTL and testbench

- Sequences the push-button window motor.
- Arbitrates press events from two requesters (driver, passenger) with a driver lockout.
- Enforces limit-switch stops, a motor-off dead time before any direction reversal, and a travel timeout fault.
- Drives the motor direction lines Open_CW / Close_CCW directly; sits between the door switch panel and the motor driver.

---
 rtl/pbw_motor_sequencer_if.sv | 34 +++
 rtl/pbw_motor_sequencer.sv | 169 ++++++++++++++++
 tb/tb_pbw_motor_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pbw_motor_sequencer_if.sv
// Panel/motor signal bundle for the push-button window sequencer.
//
// Signalling contract (there is no valid/ready pair on this block):
//   - Drv_Press / Pas_Press are button levels sampled on every rising Clock
//     edge. Only a 0->1 change between two samples counts as a press, so a
//     held button never retriggers.
//   - Lockout, Lim_Open and Lim_Closed are levels sampled on every rising edge.
//   - Open_CW, Close_CCW, Busy and Fault are Moore outputs decoded from the
//     registered state. They change only after a rising edge, or at once on reset.
//   - state_dbg mirrors the FSM state encoding so that checkers can observe it.
interface pbw_motor_sequencer_if;
    logic       Drv_Press;
    logic       Pas_Press;
    logic       Lockout;
    logic       Lim_Open;
    logic       Lim_Closed;
    logic       Open_CW;
    logic       Close_CCW;
    logic       Busy;
    logic       Fault;
    logic [2:0] state_dbg;

    // The switch panel and limit switches drive the inputs.
    modport master (
        output Drv_Press, Pas_Press, Lockout, Lim_Open, Lim_Closed,
        input  Open_CW, Close_CCW, Busy, Fault, state_dbg
    );

    // The sequencer consumes the inputs and drives the motor lines.
    modport slave (
        input  Drv_Press, Pas_Press, Lockout, Lim_Open, Lim_Closed,
        output Open_CW, Close_CCW, Busy, Fault, state_dbg
    );
endinterface

// File: rtl/pbw_motor_sequencer.sv
// Push-button window motor sequencer.
// This block arbitrates driver and passenger presses, and the driver can lock
// out the passenger button. It stops the motor at the limit switches. It keeps
// the motor off for a dead time before any reversal. It latches a fault when
// travel runs too long or when both limits read active at the same time.
module pbw_motor_sequencer #(
    parameter int DEAD_CYCLES = 4,
    parameter int TRAVEL_MAX  = 1000,
    parameter int CNT_W       = 16
) (
    input  logic                  Clock,
    input  logic                  Reset,
    pbw_motor_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_OPENING = 3'd1,
        ST_CLOSING = 3'd2,
        ST_DEAD    = 3'd3,
        ST_FAULT   = 3'd4
    } state_t;

    typedef enum logic {
        DIR_CLOSE = 1'b0,
        DIR_OPEN  = 1'b1
    } dir_t;

    localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_MAX - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST   = CNT_W'(DEAD_CYCLES - 1);

    state_t           state;
    dir_t             last_dir;
    dir_t             pending_dir;
    logic [CNT_W-1:0] travel_cnt;
    logic [CNT_W-1:0] dead_cnt;
    logic             drv_q;
    logic             pas_q;

    logic             ev_drv;
    logic             ev_pas;
    logic             ev_any;
    logic             both_lim;
    logic             travel_done;
    logic             dead_done;
    logic             pending_at_limit;
    dir_t             idle_dir;

    // Detect press edges, choose the start direction and find expiry conditions.
    always_comb begin
        ev_drv           = bus.Drv_Press & ~drv_q;
        // The passenger edge is dropped while locked out. When the driver edge
        // arrives in the same cycle, both edges merge into one event.
        ev_pas           = bus.Pas_Press & ~pas_q & ~bus.Lockout;
        ev_any           = ev_drv | ev_pas;
        both_lim         = bus.Lim_Open & bus.Lim_Closed;
        travel_done      = (travel_cnt == TRAVEL_LAST);
        dead_done        = (dead_cnt == DEAD_LAST);
        pending_at_limit = (pending_dir == DIR_OPEN) ? bus.Lim_Open : bus.Lim_Closed;
        // A limit switch fixes the direction. Without one, go opposite to the last travel.
        idle_dir         = DIR_OPEN;
        if (bus.Lim_Closed) begin
            idle_dir = DIR_OPEN;
        end else if (bus.Lim_Open) begin
            idle_dir = DIR_CLOSE;
        end else if (last_dir == DIR_CLOSE) begin
            idle_dir = DIR_OPEN;
        end else begin
            idle_dir = DIR_CLOSE;
        end
    end

    // Sequencer FSM with press history, travel and dead-time counters.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state       <= ST_IDLE;
            last_dir    <= DIR_CLOSE;
            pending_dir <= DIR_CLOSE;
            travel_cnt  <= '0;
            dead_cnt    <= '0;
            drv_q       <= 1'b0;
            pas_q       <= 1'b0;
        end else begin
            drv_q <= bus.Drv_Press;
            pas_q <= bus.Pas_Press;

            // Both limits active means a broken switch. That overrides every other move.
            if (both_lim && (state != ST_FAULT)) begin
                state <= ST_FAULT;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (ev_any) begin
                            travel_cnt <= '0;
                            state      <= (idle_dir == DIR_OPEN) ? ST_OPENING : ST_CLOSING;
                        end
                    end

                    ST_OPENING: begin
                        if (bus.Lim_Open) begin
                            state    <= ST_IDLE;
                            last_dir <= DIR_OPEN;
                        end else if (ev_any) begin
                            state       <= ST_DEAD;
                            pending_dir <= DIR_CLOSE;
                            dead_cnt    <= '0;
                        end else if (travel_done) begin
                            state <= ST_FAULT;
                        end else begin
                            travel_cnt <= travel_cnt + 1'b1;
                        end
                    end

                    ST_CLOSING: begin
                        if (bus.Lim_Closed) begin
                            state    <= ST_IDLE;
                            last_dir <= DIR_CLOSE;
                        end else if (ev_any) begin
                            state       <= ST_DEAD;
                            pending_dir <= DIR_OPEN;
                            dead_cnt    <= '0;
                        end else if (travel_done) begin
                            state <= ST_FAULT;
                        end else begin
                            travel_cnt <= travel_cnt + 1'b1;
                        end
                    end

                    ST_DEAD: begin
                        // Presses are ignored here. Their edges are still recorded
                        // in the history registers above, so they do not fire later.
                        if (dead_done) begin
                            if (pending_at_limit) begin
                                state    <= ST_IDLE;
                                last_dir <= pending_dir;
                            end else begin
                                travel_cnt <= '0;
                                state      <= (pending_dir == DIR_OPEN) ? ST_OPENING : ST_CLOSING;
                            end
                        end else begin
                            dead_cnt <= dead_cnt + 1'b1;
                        end
                    end

                    ST_FAULT: begin
                        // Only the driver can clear a fault. The motor stays off and last_dir is kept.
                        if (ev_drv) begin
                            state <= ST_IDLE;
                        end
                    end

                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Moore decode of the registered state. The two direction lines are mutually exclusive by construction.
    always_comb begin
        bus.Open_CW   = (state == ST_OPENING);
        bus.Close_CCW = (state == ST_CLOSING);
        bus.Busy      = (state == ST_OPENING) || (state == ST_CLOSING) || (state == ST_DEAD);
        bus.Fault     = (state == ST_FAULT);
        bus.state_dbg = state;
    end

endmodule

// File: tb/tb_pbw_motor_sequencer.sv
// Self-checking bench for pbw_motor_sequencer with DEAD_CYCLES=4 and TRAVEL_MAX=20.
// A behavioural reference model runs alongside the DUT. On every clock edge it
// pushes its expected output vector {Open_CW, Close_CCW, Busy, Fault}, and that
// vector is popped and compared once the DUT outputs have settled. Directed
// checks add hand-derived values for reset, latency, the dead time, the
// timeout and the retrigger cases.
module tb_pbw_motor_sequencer;
    localparam int DEAD_CYCLES = 4;
    localparam int TRAVEL_MAX  = 20;
    localparam int CNT_W       = 16;

    localparam int M_IDLE  = 0;
    localparam int M_OPEN  = 1;
    localparam int M_CLOSE = 2;
    localparam int M_DEAD  = 3;
    localparam int M_FAULT = 4;

    logic Clock;
    logic Reset;

    pbw_motor_sequencer_if bus();

    pbw_motor_sequencer #(
        .DEAD_CYCLES (DEAD_CYCLES),
        .TRAVEL_MAX  (TRAVEL_MAX),
        .CNT_W       (CNT_W)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    // Clock and watchdog.
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard state.
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [3:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model.
    int m_state;
    int m_run;
    int m_dead;
    bit m_last_open;
    bit m_pend_open;
    bit m_pd;
    bit m_pp;

    task automatic model_reset();
        m_state     = M_IDLE;
        m_run       = 0;
        m_dead      = 0;
        m_last_open = 1'b0;
        m_pend_open = 1'b0;
        m_pd        = 1'b0;
        m_pp        = 1'b0;
    endtask

    task automatic model_step();
        bit ev_d;
        bit ev_p;
        bit ev;
        bit lo;
        bit lc;
        ev_d = bus.Drv_Press && !m_pd;
        ev_p = bus.Pas_Press && !m_pp && !bus.Lockout;
        ev   = ev_d || ev_p;
        lo   = bus.Lim_Open;
        lc   = bus.Lim_Closed;
        m_pd = bus.Drv_Press;
        m_pp = bus.Pas_Press;
        if (lo && lc && m_state != M_FAULT) begin
            m_state = M_FAULT;
        end else begin
            case (m_state)
                M_IDLE: begin
                    if (ev) begin
                        m_run = 0;
                        if (lc)               m_state = M_OPEN;
                        else if (lo)          m_state = M_CLOSE;
                        else if (m_last_open) m_state = M_CLOSE;
                        else                  m_state = M_OPEN;
                    end
                end
                M_OPEN, M_CLOSE: begin
                    m_run++;
                    if ((m_state == M_OPEN && lo) || (m_state == M_CLOSE && lc)) begin
                        m_last_open = (m_state == M_OPEN);
                        m_state     = M_IDLE;
                    end else if (ev) begin
                        m_pend_open = (m_state == M_CLOSE);
                        m_dead      = 0;
                        m_state     = M_DEAD;
                    end else if (m_run == TRAVEL_MAX) begin
                        m_state = M_FAULT;
                    end
                end
                M_DEAD: begin
                    m_dead++;
                    if (m_dead == DEAD_CYCLES) begin
                        if (m_pend_open ? lo : lc) begin
                            m_last_open = m_pend_open;
                            m_state     = M_IDLE;
                        end else begin
                            m_run   = 0;
                            m_state = m_pend_open ? M_OPEN : M_CLOSE;
                        end
                    end
                end
                default: begin
                    if (ev_d) m_state = M_IDLE;
                end
            endcase
        end
    endtask

    function automatic logic [3:0] model_out();
        return {m_state == M_OPEN, m_state == M_CLOSE,
                m_state == M_OPEN || m_state == M_CLOSE || m_state == M_DEAD,
                m_state == M_FAULT};
    endfunction

    function automatic logic [3:0] dut_out();
        return {bus.Open_CW, bus.Close_CCW, bus.Busy, bus.Fault};
    endfunction

    // Driver tasks.
    task automatic set_in(input logic d, input logic p, input logic l, input logic o, input logic c);
        bus.Drv_Press  = d;
        bus.Pas_Press  = p;
        bus.Lockout    = l;
        bus.Lim_Open   = o;
        bus.Lim_Closed = c;
    endtask

    // One clock: advance the model, queue its expectation, then compare against the settled DUT.
    task automatic tick(input string tag);
        @(posedge Clock);
        if (!Reset) model_reset();
        else        model_step();
        exp_q.push_back(model_out());
        #1;
        check_eq(tag, 32'(dut_out()), 32'(exp_q.pop_front()));
        check_eq("excl", 32'(bus.Open_CW & bus.Close_CCW), 32'd0);
    endtask

    int  dead_seen;
    int  open_cnt;
    int  entries;
    int  n;
    bit  prev_mot;
    bit  mot;

    initial begin
        Reset = 1'b0;
        set_in(0, 0, 0, 0, 0);
        model_reset();
        tick("rst");
        tick("rst");
        check_eq("rst_outs", 32'(dut_out()), 32'd0);
        Reset = 1'b1;

        // T1: async reset mid-motion, then restart and stop at the open limit.
        set_in(1, 0, 0, 0, 1);
        tick("t1_press");
        check_eq("t1_open", 32'(bus.Open_CW), 32'd1);
        set_in(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick("t1_run");
        #2;
        Reset = 1'b0;
        #1;
        model_reset();
        check_eq("t1_async_rst", 32'(dut_out()), 32'd0);
        tick("t1_rst");
        Reset = 1'b1;
        set_in(1, 0, 0, 0, 1);
        tick("t1_start");
        check_eq("t1_latency", 32'(bus.Open_CW), 32'd1);
        set_in(0, 0, 0, 0, 0);
        for (int i = 2; i < 8; i++) tick("t1_travel");
        set_in(0, 0, 0, 1, 0);
        tick("t1_limit");
        check_eq("t1_stop", 32'(dut_out()), 32'd0);

        // T2: simultaneous presses form one event. Lockout masks the passenger.
        Reset = 1'b0;
        set_in(0, 0, 0, 0, 0);
        tick("t2_rst");
        Reset = 1'b1;
        set_in(1, 1, 0, 0, 0);
        tick("t2_both");
        check_eq("t2_single_open", 32'(dut_out()), 32'b1010);
        set_in(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick("t2_run");
        check_eq("t2_no_rev", 32'(dut_out()), 32'b1010);
        set_in(0, 0, 0, 1, 0);
        tick("t2_limit");
        for (int i = 0; i < 3; i++) begin
            set_in(0, 1, 1, 1, 0);
            tick("t2_lock_hi");
            set_in(0, 0, 1, 1, 0);
            tick("t2_lock_lo");
            check_eq("t2_lockout", 32'(dut_out()), 32'd0);
        end
        set_in(0, 1, 0, 1, 0);
        tick("t2_pas");
        check_eq("t2_pas_ok", 32'(dut_out()), 32'b0110);
        set_in(0, 0, 0, 0, 0);
        tick("t2_close");
        set_in(0, 0, 0, 0, 1);
        tick("t2_closed");

        // T3: a press while opening inserts exactly DEAD_CYCLES off cycles, then the motor closes.
        set_in(1, 0, 0, 0, 1);
        tick("t3_press");
        set_in(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick("t3_run");
        set_in(1, 0, 0, 0, 0);
        tick("t3_rev");
        check_eq("t3_dead_enter", 32'(dut_out()), 32'b0010);
        dead_seen = 1;
        n = 0;
        while (!bus.Close_CCW && n < 20) begin
            set_in(n == 1, 0, 0, 0, 0);
            tick("t3_dead");
            if (bus.Busy && !bus.Open_CW && !bus.Close_CCW) dead_seen++;
            n++;
        end
        check_eq("t3_dead_len", 32'(dead_seen), 32'(DEAD_CYCLES));
        check_eq("t3_closing", 32'(dut_out()), 32'b0110);
        set_in(0, 0, 0, 0, 0);
        tick("t3_after");
        tick("t3_after");
        check_eq("t3_no_effect", 32'(dut_out()), 32'b0110);
        set_in(0, 0, 0, 0, 1);
        tick("t3_closed");

        // T4: the travel timeout faults after exactly TRAVEL_MAX cycles. Only the driver clears it.
        set_in(1, 0, 0, 0, 1);
        tick("t4_press");
        open_cnt = bus.Open_CW ? 1 : 0;
        set_in(0, 0, 0, 0, 0);
        n = 0;
        while (!bus.Fault && n < 100) begin
            tick("t4_run");
            if (bus.Open_CW) open_cnt++;
            n++;
        end
        check_eq("t4_open_len", 32'(open_cnt), 32'(TRAVEL_MAX));
        check_eq("t4_fault", 32'(dut_out()), 32'b0001);
        set_in(0, 1, 0, 0, 0);
        tick("t4_pas");
        set_in(0, 0, 0, 0, 0);
        tick("t4_pas_rel");
        check_eq("t4_pas_ignored", 32'(dut_out()), 32'b0001);
        set_in(1, 0, 0, 0, 0);
        tick("t4_drv");
        check_eq("t4_drv_clear", 32'(dut_out()), 32'd0);
        set_in(0, 0, 0, 0, 0);
        tick("t4_rel");

        // T5: both limits active during closing force a fault.
        set_in(1, 0, 0, 1, 0);
        tick("t5_press");
        check_eq("t5_closing", 32'(dut_out()), 32'b0110);
        set_in(0, 0, 0, 0, 0);
        tick("t5_run");
        tick("t5_run");
        set_in(0, 0, 0, 1, 1);
        tick("t5_both");
        check_eq("t5_both_lim", 32'(dut_out()), 32'b0001);
        set_in(1, 0, 0, 0, 0);
        tick("t5_clear");
        check_eq("t5_cleared", 32'(dut_out()), 32'd0);
        set_in(0, 0, 0, 0, 0);
        tick("t5_rel");

        // T6: a held button starts one sequence only. A re-press after release is honoured.
        prev_mot = 1'b0;
        entries  = 0;
        for (int i = 0; i < 50; i++) begin
            set_in(1, 0, 0, i >= 10, i == 0);
            tick("t6_hold");
            mot = bus.Open_CW | bus.Close_CCW;
            if (mot && !prev_mot) entries++;
            prev_mot = mot;
        end
        check_eq("t6_one_seq", 32'(entries), 32'd1);
        check_eq("t6_idle", 32'(dut_out()), 32'd0);
        set_in(0, 0, 0, 1, 0);
        tick("t6_rel");
        set_in(1, 0, 0, 1, 0);
        tick("t6_repress");
        check_eq("t6_closing", 32'(dut_out()), 32'b0110);
        set_in(0, 0, 0, 0, 1);
        tick("t6_closed");

        // Random traffic checked against the model on every cycle.
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                   $urandom_range(0, 1) == 0, $urandom_range(0, 11) == 0,
                   $urandom_range(0, 11) == 0);
            tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
